// File: rtl/util_io_loop.sv
// IO loopback exerciser: baud-paced byte-stream generator on io_o with per-bit
// forcing, plus a synchronised, symbol-sampled view of io_i.
module util_io_loop #(
  parameter int INPUT_IO_WIDTH  = 8,
  parameter int OUTPUT_IO_WIDTH = 8,
  parameter int BASE_BAUD_DIV   = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic [11:0]                baud_freq,
  input  logic [15:0]                baud_limit,
  input  logic [4:0]                 stream_pkt_dest,
  input  logic [31:0]                stream_pkt_gap,
  input  logic [31:0]                stream_pkt_num,
  input  logic [31:0]                stream_trans_len,
  input  logic [7:0]                 stream_start_from,
  input  logic [7:0]                 stream_inc,
  input  logic                       stream_fix,
  input  logic                       stream_start,
  output logic                       stream_busy,
  input  logic [OUTPUT_IO_WIDTH-1:0] io_default,
  input  logic [OUTPUT_IO_WIDTH-1:0] io_force_default,
  output logic [OUTPUT_IO_WIDTH-1:0] io_o,
  input  logic [INPUT_IO_WIDTH-1:0]  io_i,
  output logic [INPUT_IO_WIDTH-1:0]  io_i_r,
  output logic [INPUT_IO_WIDTH-1:0]  io_state,
  output logic                       io_state_valid
);

  localparam int DIV_W = (BASE_BAUD_DIV > 1) ? $clog2(BASE_BAUD_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BASE_BAUD_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_GAP = 2'd2} state_t;

  logic [16:0]                acc_r, acc_sum_s, acc_nxt_s;
  logic                       tick_s, strobe_s, start_rise_s;
  logic [DIV_W-1:0]           div_r;
  logic [INPUT_IO_WIDTH-1:0]  sync1_r;
  state_t                     state_r;
  logic                       busy_r, out_data_r, start_d_r, fix_r;
  logic [7:0]                 byte_r, inc_r, rot_s;
  logic [2:0]                 dest_r;
  logic [31:0]                len_r, num_r, gap_r, byte_cnt_r, pkt_cnt_r, gap_cnt_r;
  logic [OUTPUT_IO_WIDTH-1:0] mapped_s, data_r;

  // Fractional baud accumulator: next value and tick decision
  always_comb begin
    acc_sum_s = acc_r + {5'd0, baud_freq};
    acc_nxt_s = 17'd0;
    tick_s    = 1'b0;
    if (!enable) begin
      acc_nxt_s = 17'd0;
      tick_s    = 1'b0;
    end else if ((baud_limit == 16'd0) || ({4'd0, baud_freq} >= baud_limit)) begin
      acc_nxt_s = 17'd0;
      tick_s    = 1'b1;
    end else if (acc_sum_s >= {1'b0, baud_limit}) begin
      acc_nxt_s = acc_sum_s - {1'b0, baud_limit};
      tick_s    = 1'b1;
    end else begin
      acc_nxt_s = acc_sum_s;
      tick_s    = 1'b0;
    end
  end

  assign strobe_s     = tick_s && (div_r == DIV_LAST);
  assign start_rise_s = stream_start && !start_d_r;

  // Byte rotation by the latched destination, then fit to the output width
  assign rot_s = (byte_r << dest_r) | (byte_r >> (4'd8 - {1'b0, dest_r}));
  if (OUTPUT_IO_WIDTH > 8) begin : g_ext
    assign mapped_s = {{(OUTPUT_IO_WIDTH - 8){1'b0}}, rot_s};
  end else begin : g_fit
    assign mapped_s = rot_s[OUTPUT_IO_WIDTH-1:0];
  end

  // Baud accumulator and symbol divider
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r <= 17'd0;
      div_r <= '0;
    end else begin
      acc_r <= acc_nxt_s;
      if (!enable) begin
        div_r <= '0;
      end else if (tick_s) begin
        div_r <= (div_r == DIV_LAST) ? '0 : div_r + DIV_W'(1);
      end
    end
  end

  // Input synchroniser and per-symbol sampling
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_r        <= '0;
      io_i_r         <= '0;
      io_state       <= '0;
      io_state_valid <= 1'b0;
    end else begin
      sync1_r        <= io_i;
      io_i_r         <= sync1_r;
      io_state_valid <= strobe_s;
      if (strobe_s) begin
        io_state <= io_i_r;
      end
    end
  end

  // Stream FSM; the final byte of a run stays visible until the next strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      out_data_r <= 1'b0;
      start_d_r  <= 1'b0;
      data_r     <= '0;
      byte_r     <= 8'd0;
      inc_r      <= 8'd0;
      fix_r      <= 1'b0;
      dest_r     <= 3'd0;
      len_r      <= 32'd0;
      num_r      <= 32'd0;
      gap_r      <= 32'd0;
      byte_cnt_r <= 32'd0;
      pkt_cnt_r  <= 32'd0;
      gap_cnt_r  <= 32'd0;
    end else begin
      start_d_r <= stream_start;
      if (!enable) begin
        state_r    <= ST_IDLE;
        busy_r     <= 1'b0;
        out_data_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (strobe_s) out_data_r <= 1'b0;
            if (start_rise_s && (stream_pkt_num != 32'd0)) begin
              state_r    <= ST_DATA;
              busy_r     <= 1'b1;
              byte_r     <= stream_start_from;
              inc_r      <= stream_inc;
              fix_r      <= stream_fix;
              dest_r     <= 3'(stream_pkt_dest % 5'd8);
              len_r      <= (stream_trans_len == 32'd0) ? 32'd1 : stream_trans_len;
              num_r      <= stream_pkt_num;
              gap_r      <= stream_pkt_gap;
              byte_cnt_r <= 32'd0;
              pkt_cnt_r  <= 32'd0;
              gap_cnt_r  <= 32'd0;
            end
          end
          ST_DATA: begin
            if (strobe_s) begin
              out_data_r <= 1'b1;
              data_r     <= mapped_s;
              if (!fix_r) byte_r <= byte_r + inc_r;
              if (byte_cnt_r + 32'd1 == len_r) begin
                byte_cnt_r <= 32'd0;
                if (pkt_cnt_r + 32'd1 == num_r) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end else begin
                  pkt_cnt_r <= pkt_cnt_r + 32'd1;
                  if (gap_r != 32'd0) begin
                    state_r   <= ST_GAP;
                    gap_cnt_r <= 32'd0;
                  end
                end
              end else begin
                byte_cnt_r <= byte_cnt_r + 32'd1;
              end
            end
          end
          ST_GAP: begin
            if (strobe_s) begin
              out_data_r <= 1'b0;
              if (gap_cnt_r + 32'd1 == gap_r) begin
                state_r   <= ST_DATA;
                gap_cnt_r <= 32'd0;
              end else begin
                gap_cnt_r <= gap_cnt_r + 32'd1;
              end
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            out_data_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign stream_busy = busy_r;
  assign io_o = out_data_r ? ((data_r & ~io_force_default) | (io_default & io_force_default))
                           : io_default;

endmodule

// File: tb/tb_util_io_loop.sv
// Randomised bench for util_io_loop: a symbol-level queue model checked every cycle,
// plus directed runs pinned to hand-computed literals.
module tb_util_io_loop;
  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        rstn, enable, stream_fix, stream_start, stream_busy, io_state_valid;
  logic [11:0] baud_freq;
  logic [15:0] baud_limit;
  logic [4:0]  stream_pkt_dest;
  logic [31:0] stream_pkt_gap, stream_pkt_num, stream_trans_len;
  logic [7:0]  stream_start_from, stream_inc;
  logic [7:0]  io_default, io_force_default, io_o, io_i, io_i_r, io_state;

  int total = 0;
  int bad   = 0;
  bit live_rand = 1'b0;

  util_io_loop #(.INPUT_IO_WIDTH(8), .OUTPUT_IO_WIDTH(8), .BASE_BAUD_DIV(DIV)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .baud_freq(baud_freq), .baud_limit(baud_limit),
    .stream_pkt_dest(stream_pkt_dest), .stream_pkt_gap(stream_pkt_gap),
    .stream_pkt_num(stream_pkt_num), .stream_trans_len(stream_trans_len),
    .stream_start_from(stream_start_from), .stream_inc(stream_inc), .stream_fix(stream_fix),
    .stream_start(stream_start), .stream_busy(stream_busy), .io_default(io_default),
    .io_force_default(io_force_default), .io_o(io_o), .io_i(io_i), .io_i_r(io_i_r),
    .io_state(io_state), .io_state_valid(io_state_valid)
  );

  always #5 clk = ~clk;

  // Model state: a queue of symbols (byte value, or -1 for a gap symbol)
  int   q[$];
  int   m_acc = 0, m_div = 0, m_dest = 0, m_data = 0, mt_nxt, mt_item;
  bit   m_busy = 0, m_out = 0, m_valid = 0, m_start_prev = 0, mt_tick, mt_strobe;
  logic [7:0] m_h1 = 8'h00, m_ir = 8'h00, m_state = 8'h00;

  function automatic int rotl(input int b, input int s);
    int k;
    k = s % 8;
    return ((b << k) | (b >> (8 - k))) & 255;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (got no event, required one) at %0t", nm, $time);
  endtask

  always @(posedge clk) begin
    if (!rstn) begin
      m_acc = 0; m_div = 0; m_busy = 0; m_out = 0; m_valid = 0; m_start_prev = 0;
      m_h1 = 8'h00; m_ir = 8'h00; m_state = 8'h00;
      q.delete();
    end else begin
      mt_tick = 0;
      if (!enable) m_acc = 0;
      else if (baud_limit == 0 || baud_freq >= baud_limit) begin mt_tick = 1; m_acc = 0; end
      else begin
        mt_nxt = m_acc + int'(baud_freq);
        if (mt_nxt >= int'(baud_limit)) begin mt_tick = 1; m_acc = mt_nxt - int'(baud_limit); end
        else m_acc = mt_nxt;
      end
      mt_strobe = 0;
      if (!enable) m_div = 0;
      else if (mt_tick) begin m_div = (m_div + 1) % DIV; mt_strobe = (m_div == 0); end
      m_valid = mt_strobe;
      if (mt_strobe) m_state = m_ir;
      m_ir = m_h1;
      m_h1 = io_i;
      if (!enable) begin
        m_busy = 0; m_out = 0; q.delete();
      end else if (m_busy) begin
        if (mt_strobe) begin
          mt_item = q.pop_front();
          if (mt_item < 0) m_out = 0;
          else begin m_out = 1; m_data = rotl(mt_item, m_dest); end
          if (q.size() == 0) m_busy = 0;
        end
      end else begin
        if (mt_strobe) m_out = 0;
        if (stream_start && !m_start_prev && stream_pkt_num != 0) begin
          int b, ln, pn, gp;
          b  = int'(stream_start_from);
          ln = (stream_trans_len == 0) ? 1 : int'(stream_trans_len);
          pn = int'(stream_pkt_num);
          gp = int'(stream_pkt_gap);
          for (int p = 0; p < pn; p++) begin
            for (int l = 0; l < ln; l++) begin
              q.push_back(b);
              if (!stream_fix) b = (b + int'(stream_inc)) % 256;
            end
            if (p < pn - 1) for (int g = 0; g < gp; g++) q.push_back(-1);
          end
          m_dest = int'(stream_pkt_dest);
          m_busy = 1;
        end
      end
      m_start_prev = stream_start;
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic [7:0] exp_o;
    if (!rstn) begin
      chk("rst_io_o", io_o, io_default);
      chk("rst_busy", stream_busy, 0);
      chk("rst_valid", io_state_valid, 0);
      chk("rst_io_i_r", io_i_r, 0);
      chk("rst_io_state", io_state, 0);
    end else begin
      exp_o = m_out ? ((8'(m_data) & ~io_force_default) | (io_default & io_force_default))
                    : io_default;
      chk("io_o", io_o, exp_o);
      chk("busy", stream_busy, m_busy);
      chk("valid", io_state_valid, m_valid);
      chk("io_i_r", io_i_r, m_ir);
      chk("io_state", io_state, m_state);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    io_i = 8'($urandom);
    if (live_rand && $urandom_range(0, 15) == 0) begin
      io_default       = 8'($urandom);
      io_force_default = 8'($urandom);
    end
  endtask

  task automatic kick(input logic [7:0] sf, input logic [7:0] iv, input logic fx,
                      input logic [31:0] ln, input logic [31:0] pn, input logic [31:0] gp,
                      input logic [4:0] ds);
    stream_start_from = sf; stream_inc = iv; stream_fix = fx; stream_trans_len = ln;
    stream_pkt_num = pn; stream_pkt_gap = gp; stream_pkt_dest = ds;
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int n);
    step();
    n = 1;
    while (!io_state_valid && n < 4000) begin step(); n++; end
    if (!io_state_valid) timeout(nm);
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n;
    n = 0;
    while (stream_busy && n < bound) begin step(); n++; end
    if (stream_busy) timeout(nm);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s;
    rstn = 1'b0; enable = 1'b0; baud_freq = 12'd8; baud_limit = 16'd1;
    stream_pkt_dest = 5'd0; stream_pkt_gap = 32'd0; stream_pkt_num = 32'd0;
    stream_trans_len = 32'd0; stream_start_from = 8'd0; stream_inc = 8'd0;
    stream_fix = 1'b0; stream_start = 1'b0; io_default = 8'h3C; io_force_default = 8'h00;
    io_i = 8'h00;
    repeat (3) step();
    chk("reset_io_o_lit", io_o, 8'h3C);
    chk("reset_busy_lit", stream_busy, 1'b0);
    rstn = 1'b1;
    enable = 1'b1;
    step();

    // Symbol rate: 8 ticks per strobe with one tick per cycle, then 3/8 ticks per cycle
    wait_valid("sync_valid", n);
    wait_valid("period_8", n);
    chk("strobe_period_8", n, 8);
    baud_freq = 12'd3; baud_limit = 16'd8;
    wait_valid("sync_3of8", n);
    s = 0;
    for (int k = 0; k < 3; k++) begin wait_valid("period_3of8", n); s += n; end
    chk("three_strobes_3of8", s, 64);
    baud_freq = 12'd8; baud_limit = 16'd1;

    // Forcing: default 0x05 on forced bits 0x05
    io_default = 8'h05; io_force_default = 8'h05;
    kick(8'hFA, 8'h00, 1'b1, 32'd2, 32'd1, 32'd0, 5'd0);
    wait_valid("force_fa", n);
    chk("force_fa_lit", io_o, 8'hFF);
    wait_idle("force_fa_idle", 200);
    kick(8'h00, 8'h00, 1'b1, 32'd1, 32'd1, 32'd0, 5'd0);
    wait_valid("force_00", n);
    chk("force_00_lit", io_o, 8'h05);
    wait_idle("force_00_idle", 200);

    // Fixed data and rotation
    io_default = 8'hC3; io_force_default = 8'h00;
    kick(8'hA5, 8'h11, 1'b1, 32'd2, 32'd1, 32'd0, 5'd0);
    wait_valid("fix_a", n);
    chk("fix_a5_first", io_o, 8'hA5);
    wait_valid("fix_b", n);
    chk("fix_a5_second", io_o, 8'hA5);
    wait_idle("fix_idle", 200);
    kick(8'h12, 8'h00, 1'b1, 32'd1, 32'd1, 32'd0, 5'd4);
    wait_valid("dest4", n);
    chk("dest4_lit", io_o, 8'h21);
    wait_idle("dest4_idle", 200);

    // len 0 acts as 1; two packets with a one-symbol gap; byte value carries over
    kick(8'h07, 8'h03, 1'b0, 32'd0, 32'd2, 32'd1, 5'd0);
    wait_valid("len0_a", n);
    chk("len0_byte0", io_o, 8'h07);
    wait_valid("len0_b", n);
    chk("len0_gap", io_o, 8'hC3);
    wait_valid("len0_c", n);
    chk("len0_byte1", io_o, 8'h0A);
    chk("len0_done_busy", stream_busy, 1'b0);

    // pkt_num 0 ignored
    kick(8'h01, 8'h01, 1'b0, 32'd1, 32'd0, 32'd0, 5'd0);
    repeat (20) step();
    chk("pktnum0_busy", stream_busy, 1'b0);

    // start held high: exactly one run
    stream_start_from = 8'h30; stream_inc = 8'h01; stream_fix = 1'b0; stream_trans_len = 32'd1;
    stream_pkt_num = 32'd2; stream_pkt_gap = 32'd0; stream_pkt_dest = 5'd0;
    stream_start = 1'b1;
    step();
    wait_idle("held_idle", 400);
    repeat (40) step();
    chk("held_single_run", stream_busy, 1'b0);
    stream_start = 1'b0;
    step();

    // Abort by enable
    kick(8'h40, 8'h01, 1'b0, 32'd4, 32'd3, 32'd2, 5'd1);
    wait_valid("abort_a", n);
    wait_valid("abort_b", n);
    enable = 1'b0;
    step();
    chk("abort_busy", stream_busy, 1'b0);
    chk("abort_io_o", io_o, 8'hC3);
    enable = 1'b1;
    repeat (4) step();

    // Asynchronous reset mid-run
    kick(8'h50, 8'h02, 1'b0, 32'd4, 32'd3, 32'd2, 5'd0);
    wait_valid("rst_mid", n);
    rstn = 1'b0;
    #1;
    chk("async_busy", stream_busy, 1'b0);
    chk("async_io_o", io_o, 8'hC3);
    chk("async_io_state", io_state, 8'h00);
    chk("async_io_i_r", io_i_r, 8'h00);
    repeat (2) step();
    rstn = 1'b1;
    step();

    // Randomised runs against the queue model, with live default/force changes
    live_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      baud_freq  = 12'($urandom_range(1, 12));
      baud_limit = 16'($urandom_range(0, 24));
      kick(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 4)), 32'($urandom_range(1, 4)), 32'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)));
      wait_idle("rand_idle", 20000);
      repeat (10) step();
    end
    live_rand = 1'b0;

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
